// File: rtl/lrn_addr_mapper.sv
// Address generator for the LRN stage: walks an N x M x E x F feature map for GLB
// reads and emits the matching padded write-back addresses, with a bounded read-ahead window.
module lrn_addr_mapper #(
  parameter int N_WIDTH        = 2,
  parameter int M_WIDTH        = 10,
  parameter int E_WIDTH        = 6,
  parameter int F_WIDTH        = 6,
  parameter int V_WIDTH        = 2,
  parameter int ADDR_BUS_WIDTH = 20,
  parameter int LEAD_DEPTH     = 16
) (
  input  logic                      core_clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [N_WIDTH-1:0]        dim4,
  input  logic [M_WIDTH-1:0]        dim3,
  input  logic [E_WIDTH-1:0]        dim2,
  input  logic [F_WIDTH-1:0]        dim1,
  input  logic [V_WIDTH-1:0]        padding_num,
  input  logic                      col_major,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [ADDR_BUS_WIDTH-1:0] rd_addr,
  input  logic                      wr_data_valid,
  output logic                      wr_en,
  output logic [ADDR_BUS_WIDTH-1:0] wr_addr,
  output logic                      busy,
  output logic                      done,
  output logic                      cfg_error,
  output logic                      seq_error
);

  // Wide enough that no intermediate product of the padded write address can overflow.
  localparam int SUM_W  = N_WIDTH + M_WIDTH + E_WIDTH + F_WIDTH + 2 * V_WIDTH + 4;
  localparam int FULL_W = (SUM_W > ADDR_BUS_WIDTH) ? SUM_W : ADDR_BUS_WIDTH;
  localparam int OUT_W  = $clog2(LEAD_DEPTH + 1);
  localparam logic [OUT_W-1:0] LEAD_MAX = OUT_W'(LEAD_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                    state_reg;
  logic [N_WIDTH-1:0]        n_cfg_reg;
  logic [M_WIDTH-1:0]        m_cfg_reg;
  logic [E_WIDTH-1:0]        e_cfg_reg;
  logic [F_WIDTH-1:0]        f_cfg_reg;
  logic [V_WIDTH-1:0]        p_cfg_reg;
  logic                      col_cfg_reg;
  logic [OUT_W-1:0]          outstanding_reg;
  logic [OUT_W-1:0]          outstanding_next;
  logic                      wr_en_reg;
  logic [ADDR_BUS_WIDTH-1:0] wr_addr_reg;
  logic                      done_reg;
  logic                      cfg_error_reg;
  logic                      seq_error_reg;

  logic                      active;
  logic                      rd_accept;
  logic                      wr_accept;
  logic                      seq_fault;
  logic                      cfg_zero;
  logic                      idx_clear;
  logic [1:0]                step;
  logic [1:0]                last;
  logic [ADDR_BUS_WIDTH-1:0] addr_calc [2];

  assign active    = (state_reg == RUN) || (state_reg == DRAIN);
  assign rd_valid  = (state_reg == RUN) && (outstanding_reg < LEAD_MAX);
  assign rd_accept = rd_valid && rd_ready;
  assign wr_accept = wr_data_valid && active && (outstanding_reg != '0) && !abort;
  assign seq_fault = wr_data_valid && !(active && (outstanding_reg != '0));
  assign cfg_zero  = (dim4 == '0) || (dim3 == '0) || (dim2 == '0) || (dim1 == '0);
  assign idx_clear = (state_reg == IDLE) || abort;
  assign step      = {wr_accept, rd_accept};

  always_comb begin
    outstanding_next = outstanding_reg;
    if (rd_accept && !wr_accept) begin
      outstanding_next = outstanding_reg + OUT_W'(1);
    end else if (!rd_accept && wr_accept) begin
      outstanding_next = outstanding_reg - OUT_W'(1);
    end
  end

  // Port 0 is the read walker (no padding), port 1 the write walker (padded by P).
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [N_WIDTH-1:0] n_reg;
      logic [M_WIDTH-1:0] m_reg;
      logic [E_WIDTH-1:0] h_reg;
      logic [F_WIDTH-1:0] w_reg;
      logic               m_wrap;
      logic               w_wrap;
      logic               h_wrap;
      logic               n_wrap;
      logic [FULL_W-1:0]  pad;
      logic [FULL_W-1:0]  pe;
      logic [FULL_W-1:0]  pf;
      logic [FULL_W-1:0]  nm;
      logic [FULL_W-1:0]  row_addr;
      logic [FULL_W-1:0]  col_addr;

      assign m_wrap   = (m_reg == m_cfg_reg - M_WIDTH'(1));
      assign w_wrap   = (w_reg == f_cfg_reg - F_WIDTH'(1));
      assign h_wrap   = (h_reg == e_cfg_reg - E_WIDTH'(1));
      assign n_wrap   = (n_reg == n_cfg_reg - N_WIDTH'(1));
      assign last[gi] = m_wrap && w_wrap && h_wrap && n_wrap;

      always_ff @(posedge core_clk or negedge reset_n) begin
        if (!reset_n) begin
          n_reg <= '0;
          m_reg <= '0;
          h_reg <= '0;
          w_reg <= '0;
        end else if (idx_clear) begin
          n_reg <= '0;
          m_reg <= '0;
          h_reg <= '0;
          w_reg <= '0;
        end else if (step[gi]) begin
          if (!m_wrap) begin
            m_reg <= m_reg + M_WIDTH'(1);
          end else begin
            m_reg <= '0;
            if (!w_wrap) begin
              w_reg <= w_reg + F_WIDTH'(1);
            end else begin
              w_reg <= '0;
              if (!h_wrap) begin
                h_reg <= h_reg + E_WIDTH'(1);
              end else begin
                h_reg <= '0;
                n_reg <= n_wrap ? '0 : n_reg + N_WIDTH'(1);
              end
            end
          end
        end
      end

      assign pad      = (gi == 1) ? FULL_W'(p_cfg_reg) : '0;
      assign pe       = FULL_W'(e_cfg_reg) + pad + pad;
      assign pf       = FULL_W'(f_cfg_reg) + pad + pad;
      assign nm       = FULL_W'(n_reg) * FULL_W'(m_cfg_reg) + FULL_W'(m_reg);
      assign row_addr = (nm * pe + FULL_W'(h_reg) + pad) * pf + FULL_W'(w_reg) + pad;
      assign col_addr = (nm * pf + FULL_W'(w_reg) + pad) * pe + FULL_W'(h_reg) + pad;
      assign addr_calc[gi] = ADDR_BUS_WIDTH'(col_cfg_reg ? col_addr : row_addr);
    end
  endgenerate

  always_ff @(posedge core_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      n_cfg_reg       <= '0;
      m_cfg_reg       <= '0;
      e_cfg_reg       <= '0;
      f_cfg_reg       <= '0;
      p_cfg_reg       <= '0;
      col_cfg_reg     <= 1'b0;
      outstanding_reg <= '0;
      wr_en_reg       <= 1'b0;
      wr_addr_reg     <= '0;
      done_reg        <= 1'b0;
      cfg_error_reg   <= 1'b0;
      seq_error_reg   <= 1'b0;
    end else begin
      wr_en_reg     <= wr_accept;
      wr_addr_reg   <= wr_accept ? addr_calc[1] : '0;
      seq_error_reg <= seq_fault;
      cfg_error_reg <= 1'b0;
      done_reg      <= 1'b0;
      case (state_reg)
        IDLE: begin
          outstanding_reg <= '0;
          if (start) begin
            if (cfg_zero) begin
              cfg_error_reg <= 1'b1;
            end else begin
              n_cfg_reg   <= dim4;
              m_cfg_reg   <= dim3;
              e_cfg_reg   <= dim2;
              f_cfg_reg   <= dim1;
              p_cfg_reg   <= padding_num;
              col_cfg_reg <= col_major;
              state_reg   <= RUN;
            end
          end
        end
        RUN, DRAIN: begin
          if (abort) begin
            state_reg       <= IDLE;
            outstanding_reg <= '0;
          end else begin
            outstanding_reg <= outstanding_next;
            if ((state_reg == RUN) && rd_accept && last[0]) begin
              state_reg <= DRAIN;
            end
            // done is raised together with the final wr_en.
            if ((state_reg == DRAIN) && wr_accept && last[1]) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end
          end
        end
        DONE: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rd_addr   = addr_calc[0];
  assign wr_en     = wr_en_reg;
  assign wr_addr   = wr_addr_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign cfg_error = cfg_error_reg;
  assign seq_error = seq_error_reg;

endmodule
